div_share_arb: RTL and testbench

- Round-robin scheduler that time-shares one serial divider (START/BUSY/QUOT/REM interface) among up to four display-side requesters, e.g. main-mode digit split, sub-mode digit split and BER scaling.
- Replaces per-requester div instances in the 7-segment display path.
- Latches the winner's operands, sequences the divider, and returns the registered result with a one-cycle DONE pulse to that requester only.

---
 rtl/div_share_arb.sv | 176 +++++++++++++++++
 tb/tb_div_share_arb.sv | 415 ++++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/div_share_arb.sv
`default_nettype none
// ============================================================================
// Module   : div_share_arb
// Purpose  : Round-robin scheduler that time-shares one serial divider
//            (START/BUSY/QUOT/REM handshake) among NREQ display requesters.
//            The winner's operands are latched at grant, the divider is
//            started and awaited, and the registered result is returned
//            with a one-cycle DONE pulse to that requester only.
// Options  : DIV_ZERO_CHK_EN - when defined, a divisor of zero bypasses the
//            divider and returns QUOT=all ones, REM=0 directly.
// Revision : 1.0 - initial release
// ============================================================================
module div_share_arb #(
  parameter int NREQ    = 3,
  parameter int BW_DEND = 8,
  parameter int BW_DSOR = 4
) (
  input  logic                      CLK,
  input  logic                      RSTX,
  input  logic [NREQ-1:0]           REQ,
  input  logic [NREQ*BW_DEND-1:0]   DIVIDEND,
  input  logic [NREQ*BW_DSOR-1:0]   DIVISOR,
  output logic [NREQ-1:0]           GNT,
  output logic [NREQ-1:0]           DONE,
  output logic [BW_DEND-1:0]        QUOT,
  output logic [BW_DSOR-1:0]        REM,
  output logic                      BUSY,
  output logic                      DIV_START,
  output logic [BW_DEND-1:0]        DIV_DIVIDEND,
  output logic [BW_DSOR-1:0]        DIV_DIVISOR,
  input  logic                      DIV_BUSY,
  input  logic [BW_DEND-1:0]        DIV_QUOT,
  input  logic [BW_DSOR-1:0]        DIV_REM
);

  localparam int              PW      = $clog2(NREQ);
  localparam logic [PW:0]     C_NREQ  = (PW+1)'(NREQ);
  localparam logic [PW-1:0]   C_LAST  = PW'(NREQ - 1);
  localparam logic [NREQ-1:0] C_ONE   = NREQ'(1);

  typedef enum logic [2:0] {
    ST_IDLE    = 3'd0,
    ST_ISSUE   = 3'd1,
    ST_WAIT_HI = 3'd2,
    ST_WAIT_LO = 3'd3,
    ST_RESP    = 3'd4
  } state_t;

  state_t              state_q, state_d;
  logic [PW-1:0]       ptr_q, ptr_d;
  logic [PW-1:0]       win_q, win_d;
  logic [NREQ-1:0]     gnt_q, gnt_d;
  logic [BW_DEND-1:0]  quot_q, quot_d;
  logic [BW_DSOR-1:0]  rem_q, rem_d;
  logic [BW_DEND-1:0]  opa_q, opa_d;
  logic [BW_DSOR-1:0]  opb_q, opb_d;

  logic [BW_DEND-1:0]  dend_arr [NREQ];
  logic [BW_DSOR-1:0]  dsor_arr [NREQ];
  logic                pick_vld;
  logic [PW-1:0]       pick_idx;
  logic [PW:0]         cand;

  // Unpack the flattened operand buses into per-requester slots
  for (genvar gi = 0; gi < NREQ; gi++) begin : g_slice
    assign dend_arr[gi] = DIVIDEND[gi*BW_DEND +: BW_DEND];
    assign dsor_arr[gi] = DIVISOR[gi*BW_DSOR +: BW_DSOR];
  end

  // Round-robin pick: scan PTR, PTR+1, ... (mod NREQ); descending loop so the
  // smallest offset from PTR is the last (winning) assignment
  always_comb begin
    pick_vld = 1'b0;
    pick_idx = '0;
    cand     = '0;
    for (int k = NREQ - 1; k >= 0; k--) begin
      cand = {1'b0, ptr_q} + (PW+1)'(k);
      if (cand >= C_NREQ) begin
        cand = cand - C_NREQ;
      end
      if (REQ[cand[PW-1:0]]) begin
        pick_vld = 1'b1;
        pick_idx = cand[PW-1:0];
      end
    end
  end

  // Next-state and datapath updates for the grant/divide/respond sequence
  always_comb begin
    state_d = state_q;
    ptr_d   = ptr_q;
    win_d   = win_q;
    gnt_d   = gnt_q;
    quot_d  = quot_q;
    rem_d   = rem_q;
    opa_d   = opa_q;
    opb_d   = opb_q;
    case (state_q)
      ST_IDLE: begin
        if (pick_vld) begin
          win_d   = pick_idx;
          gnt_d   = C_ONE << pick_idx;
          opa_d   = dend_arr[pick_idx];
          opb_d   = dsor_arr[pick_idx];
          state_d = ST_ISSUE;
`ifdef DIV_ZERO_CHK_EN
          // Zero divisor never reaches the divider; answer immediately
          if (dsor_arr[pick_idx] == '0) begin
            quot_d  = '1;
            rem_d   = '0;
            state_d = ST_RESP;
          end
`endif
        end
      end
      ST_ISSUE: begin
        state_d = ST_WAIT_HI;
      end
      ST_WAIT_HI: begin
        if (DIV_BUSY) begin
          state_d = ST_WAIT_LO;
        end
      end
      ST_WAIT_LO: begin
        if (!DIV_BUSY) begin
          quot_d  = DIV_QUOT;
          rem_d   = DIV_REM;
          state_d = ST_RESP;
        end
      end
      ST_RESP: begin
        gnt_d   = '0;
        ptr_d   = (win_q == C_LAST) ? '0 : win_q + 1'b1;
        state_d = ST_IDLE;
      end
      default: begin
        gnt_d   = '0;
        state_d = ST_IDLE;
      end
    endcase
  end

  // State and datapath registers; asynchronous reset drops any in-flight op
  always_ff @(posedge CLK or negedge RSTX) begin
    if (!RSTX) begin
      state_q <= ST_IDLE;
      ptr_q   <= '0;
      win_q   <= '0;
      gnt_q   <= '0;
      quot_q  <= '0;
      rem_q   <= '0;
      opa_q   <= '0;
      opb_q   <= '0;
    end else begin
      state_q <= state_d;
      ptr_q   <= ptr_d;
      win_q   <= win_d;
      gnt_q   <= gnt_d;
      quot_q  <= quot_d;
      rem_q   <= rem_d;
      opa_q   <= opa_d;
      opb_q   <= opb_d;
    end
  end

  assign GNT          = gnt_q;
  assign DONE         = (state_q == ST_RESP) ? gnt_q : '0;
  assign QUOT         = quot_q;
  assign REM          = rem_q;
  assign BUSY         = (state_q != ST_IDLE);
  assign DIV_START    = (state_q == ST_ISSUE);
  assign DIV_DIVIDEND = opa_q;
  assign DIV_DIVISOR  = opb_q;

endmodule
`default_nettype wire

// File: tb/tb_div_share_arb.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module   : tb_div_share_arb
// Purpose  : Self-checking bench for div_share_arb. A transaction-level
//            reference model predicts every output each cycle; directed
//            scenarios pin the model with hand-computed results, then
//            randomized requesters exercise arbitration and dropping.
// Revision : 1.0 - initial release
// ============================================================================
module tb_div_share_arb;

  localparam int NREQ    = 3;
  localparam int BW_DEND = 8;
  localparam int BW_DSOR = 4;

  logic                    CLK = 1'b0;
  logic                    RSTX = 1'b0;
  logic [NREQ-1:0]         REQ = '0;
  logic [NREQ*BW_DEND-1:0] DIVIDEND = '0;
  logic [NREQ*BW_DSOR-1:0] DIVISOR = '0;
  logic [NREQ-1:0]         GNT, DONE;
  logic [BW_DEND-1:0]      QUOT, DIV_DIVIDEND;
  logic [BW_DSOR-1:0]      REM, DIV_DIVISOR;
  logic                    BUSY, DIV_START;
  logic                    div_busy;
  logic [BW_DEND-1:0]      div_q;
  logic [BW_DSOR-1:0]      div_r;

  always #5 CLK = ~CLK;

  div_share_arb #(.NREQ(NREQ), .BW_DEND(BW_DEND), .BW_DSOR(BW_DSOR)) dut (
    .CLK(CLK), .RSTX(RSTX), .REQ(REQ), .DIVIDEND(DIVIDEND), .DIVISOR(DIVISOR),
    .GNT(GNT), .DONE(DONE), .QUOT(QUOT), .REM(REM), .BUSY(BUSY),
    .DIV_START(DIV_START), .DIV_DIVIDEND(DIV_DIVIDEND), .DIV_DIVISOR(DIV_DIVISOR),
    .DIV_BUSY(div_busy), .DIV_QUOT(div_q), .DIV_REM(div_r)
  );

  int total = 0;
  int bad   = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  // ---------------- shared divider (environment) ----------------
  // Busy rises on the edge that samples START and lasts 1..5 cycles; the
  // quotient bus carries junk until completion. Divide-by-zero yields
  // quotient all ones and remainder = low dividend bits.
  int dv_cnt;
  int lat_force = 0;
  logic [BW_DEND-1:0] dv_a;
  logic [BW_DSOR-1:0] dv_b;
  always @(posedge CLK or negedge RSTX) begin
    if (!RSTX) begin
      div_busy <= 1'b0; dv_cnt <= 0; div_q <= '0; div_r <= '0; dv_a <= '0; dv_b <= '0;
    end else if (DIV_START) begin
      div_busy <= 1'b1;
      dv_cnt   <= (lat_force > 0) ? lat_force : int'($urandom_range(1, 5));
      dv_a     <= DIV_DIVIDEND;
      dv_b     <= DIV_DIVISOR;
      div_q    <= BW_DEND'($urandom);
      div_r    <= BW_DSOR'($urandom);
    end else if (div_busy) begin
      if (dv_cnt == 1) begin
        div_busy <= 1'b0;
        if (dv_b == '0) begin
          div_q <= '1;
          div_r <= dv_a[BW_DSOR-1:0];
        end else begin
          div_q <= BW_DEND'(int'(dv_a) / int'(dv_b));
          div_r <= BW_DSOR'(int'(dv_a) % int'(dv_b));
        end
      end
      dv_cnt <= dv_cnt - 1;
    end
  end

  // ---------------- reference model ----------------
  function automatic int rr_pick(input int ptr, input logic [NREQ-1:0] req);
    for (int k = 0; k < NREQ; k++) begin
      if (req[(ptr + k) % NREQ]) return (ptr + k) % NREQ;
    end
    return -1;
  endfunction

  // Expected divider answer as a {quot, rem} pair, from plain arithmetic
  function automatic logic [BW_DEND+BW_DSOR-1:0] ref_div(input int a, input int b);
    int q, r;
    if (b == 0) begin
      q = (1 << BW_DEND) - 1;
      r = a % (1 << BW_DSOR);
    end else begin
      q = a / b;
      r = a % b;
    end
    return {BW_DEND'(q), BW_DSOR'(r)};
  endfunction

  bit                 m_active, m_resp;
  int                 m_win, m_ptr, m_age, m_w;
  logic [BW_DEND-1:0] m_a, m_quot;
  logic [BW_DSOR-1:0] m_b, m_rem;

  // One operation = grant, start one cycle later, wait out the divider's
  // busy window, then one response cycle; the next grant needs an idle cycle.
  initial begin
    forever begin
      @(posedge CLK or negedge RSTX);
      if (!RSTX) begin
        m_active = 0; m_resp = 0; m_win = 0; m_ptr = 0; m_age = 0;
        m_a = '0; m_b = '0; m_quot = '0; m_rem = '0;
      end else if (m_active) begin
        if (m_resp) begin
          m_active = 0;
          m_resp   = 0;
          m_ptr    = (m_win + 1) % NREQ;
        end else begin
          m_age++;
          if (m_age >= 3 && !div_busy) begin
            m_resp = 1;
            {m_quot, m_rem} = ref_div(int'(m_a), int'(m_b));
          end
        end
      end else begin
        m_w = rr_pick(m_ptr, REQ);
        if (m_w >= 0) begin
          m_active = 1;
          m_win    = m_w;
          m_age    = 0;
          m_a      = DIVIDEND[m_w*BW_DEND +: BW_DEND];
          m_b      = DIVISOR[m_w*BW_DSOR +: BW_DSOR];
`ifdef DIV_ZERO_CHK_EN
          if (m_b == '0) begin
            m_resp = 1;
            m_quot = '1;
            m_rem  = '0;
          end
`endif
        end
      end
    end
  end

  // ---------------- compare + event monitor ----------------
  int   d_idx[$];
  int   d_q[$];
  int   d_r[$];
  int   d_g[$];
  int   start_cnt = 0;

  initial begin
    forever begin
      @(negedge CLK);
      chk("busy",      32'(BUSY),         m_active ? 32'd1 : 32'd0);
      chk("gnt",       32'(GNT),          m_active ? (32'd1 << m_win) : 32'd0);
      chk("done",      32'(DONE),         m_resp ? (32'd1 << m_win) : 32'd0);
      chk("div_start", 32'(DIV_START),    (m_active && !m_resp && m_age == 0) ? 32'd1 : 32'd0);
      chk("quot",      32'(QUOT),         32'(m_quot));
      chk("rem",       32'(REM),          32'(m_rem));
      chk("div_dend",  32'(DIV_DIVIDEND), 32'(m_a));
      chk("div_dsor",  32'(DIV_DIVISOR),  32'(m_b));
      if (DIV_START) start_cnt++;
      if (DONE != '0) begin
        for (int k = 0; k < NREQ; k++) begin
          if (DONE[k]) d_idx.push_back(k);
        end
        d_q.push_back(int'(QUOT));
        d_r.push_back(int'(REM));
        d_g.push_back(int'(GNT));
      end
    end
  end

  // ---------------- stimulus helpers ----------------
  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  task automatic set_op(input int i, input int a, input int b);
    DIVIDEND[i*BW_DEND +: BW_DEND] = BW_DEND'(a);
    DIVISOR[i*BW_DSOR +: BW_DSOR]  = BW_DSOR'(b);
  endtask

  task automatic clear_log();
    d_idx.delete(); d_q.delete(); d_r.delete(); d_g.delete();
    start_cnt = 0;
  endtask

  task automatic do_reset();
    RSTX = 1'b0;
    REQ  = '0;
    repeat (2) @(posedge CLK);
    #1;
    RSTX = 1'b1;
  endtask

  // Acts as the requesters: clears REQ on the edge that samples DONE
  // (unless kept), until ndone pulses were seen or the budget runs out.
  task automatic serve(input int ndone, input logic [NREQ-1:0] keep);
    int got, cyc;
    logic [NREQ-1:0] d;
    got = 0;
    cyc = 0;
    while (got < ndone && cyc < 400) begin
      @(posedge CLK);
      d = DONE;
      #1;
      cyc++;
      for (int i = 0; i < NREQ; i++) begin
        if (d[i]) begin
          got++;
          if (!keep[i]) REQ[i] = 1'b0;
        end
      end
    end
    chk("serve_budget", 32'(got), 32'(ndone));
  endtask

  task automatic wait_idle();
    int cyc;
    cyc = 0;
    while (BUSY && cyc < 100) begin
      tick();
      cyc++;
    end
    chk("idle_budget", 32'(BUSY), 32'd0);
  endtask

  // ---------------- test sequence ----------------
  int exp_i[3];
  int exp_q[3];
  int exp_r[3];
  int lat, cyc;
  logic [NREQ-1:0] d;

  initial begin
    // reset state
    repeat (2) @(posedge CLK);
    #1;
    chk("rst_gnt",   32'(GNT), 32'd0);
    chk("rst_done",  32'(DONE), 32'd0);
    chk("rst_quot",  32'(QUOT), 32'd0);
    chk("rst_rem",   32'(REM), 32'd0);
    chk("rst_start", 32'(DIV_START), 32'd0);
    chk("rst_busy",  32'(BUSY), 32'd0);
    RSTX = 1'b1;

    // single request 200/10
    clear_log();
    set_op(0, 200, 10);
    REQ = 3'b001;
    serve(1, '0);
    chk("single_n",     32'(d_idx.size()), 32'd1);
    if (d_idx.size() >= 1) begin
      chk("single_idx", 32'(d_idx[0]), 32'd0);
      chk("single_q",   32'(d_q[0]), 32'd20);
      chk("single_r",   32'(d_r[0]), 32'd0);
      chk("single_gnt", 32'(d_g[0]), 32'b001);
    end
    chk("single_starts", 32'(start_cnt), 32'd1);

    // simultaneous requests from reset
    RSTX = 1'b0;
    set_op(0, 123, 10); set_op(1, 45, 10); set_op(2, 7, 10);
    REQ = 3'b111;
    repeat (2) @(posedge CLK);
    #1;
    clear_log();
    RSTX = 1'b1;
    serve(3, '0);
    exp_i = '{0, 1, 2}; exp_q = '{12, 4, 0}; exp_r = '{3, 5, 7};
    chk("simul_n", 32'(d_idx.size()), 32'd3);
    for (int k = 0; k < 3; k++) begin
      if (d_idx.size() > k) begin
        chk("simul_idx", 32'(d_idx[k]), 32'(exp_i[k]));
        chk("simul_q",   32'(d_q[k]), 32'(exp_q[k]));
        chk("simul_r",   32'(d_r[k]), 32'(exp_r[k]));
      end
    end
    chk("simul_starts", 32'(start_cnt), 32'd3);

    // round robin: requester 0 re-requests, requester 2 held until served
    do_reset();
    clear_log();
    set_op(0, 11, 3); set_op(2, 14, 5);
    REQ = 3'b101;
    serve(4, 3'b001);
    REQ = '0;
    wait_idle();
    exp_i = '{0, 2, 0};
    for (int k = 0; k < 3; k++) begin
      if (d_idx.size() > k) chk("rr_order", 32'(d_idx[k]), 32'(exp_i[k]));
    end
    if (d_idx.size() > 3) chk("rr_order4", 32'(d_idx[3]), 32'd0);
    if (d_q.size() > 1) chk("rr_q2", 32'(d_q[1]), 32'd2);

    // operand latching: 99/10 changed to 50 after grant
    clear_log();
    set_op(0, 99, 10);
    REQ = 3'b001;
    cyc = 0;
    while (!GNT[0] && cyc < 20) begin
      tick();
      cyc++;
    end
    chk("latch_gnt_seen", 32'(GNT[0]), 32'd1);
    tick();
    set_op(0, 50, 10);
    serve(1, '0);
    if (d_q.size() >= 1) begin
      chk("latch_q", 32'(d_q[0]), 32'd9);
      chk("latch_r", 32'(d_r[0]), 32'd9);
    end

    // reset in the middle of a divider wait
    do_reset();
    lat_force = 6;
    set_op(0, 30, 4);
    REQ = 3'b001;
    serve(1, '0);
    set_op(1, 60, 7);
    REQ = 3'b010;
    cyc = 0;
    while (!DIV_START && cyc < 20) begin
      tick();
      cyc++;
    end
    chk("mid_start_seen", 32'(DIV_START), 32'd1);
    repeat (3) tick();
    RSTX = 1'b0;
    REQ  = '0;
    #1;
    chk("mid_rst_outs", 32'({GNT, DONE, BUSY, DIV_START}), 32'd0);
    chk("mid_rst_res",  32'({QUOT, REM, DIV_DIVIDEND, DIV_DIVISOR}), 32'd0);
    tick();
    RSTX = 1'b1;
    clear_log();
    repeat (10) tick();
    chk("mid_no_done", 32'(d_idx.size()), 32'd0);
    set_op(0, 9, 2); set_op(1, 8, 3);
    REQ = 3'b011;
    serve(2, '0);
    if (d_idx.size() >= 2) begin
      chk("mid_ptr0", 32'(d_idx[0]), 32'd0);
      chk("mid_q0",   32'(d_q[0]), 32'd4);
      chk("mid_r1",   32'(d_r[1]), 32'd2);
    end
    lat_force = 0;

    // divisor zero
    do_reset();
    clear_log();
    set_op(0, 77, 0);
    REQ = 3'b001;
    lat = 0;
    d   = '0;
    while (!d[0] && lat < 50) begin
      @(posedge CLK);
      d = DONE;
      #1;
      lat++;
    end
    REQ = '0;
    chk("zero_done_seen", 32'(d[0]), 32'd1);
    if (d_q.size() >= 1) chk("zero_q", 32'(d_q[0]), 32'd255);
`ifdef DIV_ZERO_CHK_EN
    chk("zero_lat",    32'(lat), 32'd2);
    chk("zero_starts", 32'(start_cnt), 32'd0);
    if (d_r.size() >= 1) chk("zero_r", 32'(d_r[0]), 32'd0);
`else
    chk("zero_starts", 32'(start_cnt), 32'd1);
    if (d_r.size() >= 1) chk("zero_r", 32'(d_r[0]), 32'd13);
`endif

    // randomized requesters with drops, re-requests and operand churn
    do_reset();
    for (int c = 0; c < 3000; c++) begin
      @(posedge CLK);
      d = DONE;
      #1;
      if (c == 1500) begin
        RSTX = 1'b0;
        tick();
        RSTX = 1'b1;
      end
      for (int i = 0; i < NREQ; i++) begin
        if (d[i]) begin
          if ($urandom_range(0, 1) == 0) REQ[i] = 1'b0;
          else set_op(i, int'($urandom_range(0, 255)), int'($urandom_range(0, 15)));
        end else if (REQ[i]) begin
          lat = int'($urandom_range(0, 31));
          if (lat == 0) REQ[i] = 1'b0;
          else if (lat < 4) set_op(i, int'($urandom_range(0, 255)), int'($urandom_range(0, 15)));
        end else if ($urandom_range(0, 2) == 0) begin
          set_op(i, int'($urandom_range(0, 255)), int'($urandom_range(0, 15)));
          REQ[i] = 1'b1;
        end
      end
    end
    REQ = '0;
    wait_idle();
    tick();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
`default_nettype wire
